mm_refill_ctrl: RTL
===================

// Module: mm_refill_ctrl
// PURPOSE
//  Miss-refill controller between the direct-mapped instruction cache and main memory (MM).
//  On a cache miss (HitWrite=0), fetches the word at PC from MM over a req/ack handshake.
//  Returns it to the cache as Data_MM with the Access_MM=0 strobe for exactly one cycle.
//  Counts refills, stall cycles and timeouts for performance checking.
// PARAMETERS
//  TIMEOUT  16  REQ cycles without MM_Ack before a retry is forced (>=2)
//  CNT_W    20  width of the performance counters
// PORTS
//  CLK         in   1      single clock, rising edge
//  RESET       in   1      asynchronous, active-low reset
//  PC          in   32     fetch address; held stable by the pipeline while HitWrite=0
//  HitWrite    in   1      from cache: 1=hit/proceed, 0=miss
//  Access_MM   out  1      to cache: 0=refill word valid this cycle, 1=normal lookup
//  Data_MM     out  32     refill word, valid when Access_MM=0
//  MM_Req      out  1      read request to MM
//  MM_Addr     out  32     word-aligned request address {PC[31:2],2'b00}
//  MM_Ack      in   1      MM read data valid; sampled only while MM_Req=1
//  MM_RData    in   32     MM read data
//  Busy        out  1      1 in any state except IDLE
//  Err         out  1      sticky: set on the first timeout, cleared only by reset
//  CNT_REFILL  out  CNT_W  completed refills
//  CNT_STALL   out  CNT_W  cycles spent outside IDLE
// BEHAVIOUR
//  All outputs are registered (Moore). Async reset drives IDLE and forces the reset values at once.
//  Reset values: Access_MM=1, Data_MM=0, MM_Req=0, MM_Addr=0, Busy=0, Err=0, counters=0.
//  Reset mid-refill drops MM_Req immediately. A late MM_Ack after reset is ignored.
//  FSM states:
//   IDLE:  Access_MM=1. When HitWrite=0 at an edge, latch addr_q={PC[31:2],2'b00} and go to REQ.
//   REQ:   MM_Req=1, MM_Addr=addr_q; wait counter increments each cycle.
//          MM_Ack=1 at an edge: capture MM_RData into data_q and go to FILL.
//          Ack on the first REQ cycle (zero-wait) is legal.
//          Wait counter reaching TIMEOUT-1 with no ack: set Err and go to RETRY.
//   RETRY: MM_Req=0 for one cycle, clear the wait counter, return to REQ. Refill address is unchanged.
//   FILL:  Access_MM=0, Data_MM=data_q for exactly one cycle; CNT_REFILL+1; go to COOL.
//   COOL:  Access_MM=1; ignore HitWrite for one cycle (the cache's registered HitWrite is stale); go to IDLE.
//  Miss penalty: from the IDLE edge sampling HitWrite=0, FILL is the 2nd cycle with a zero-wait ack.
//  Each extra MM wait cycle adds 1.
//  MM_Ack while MM_Req=0 (IDLE/RETRY/FILL/COOL) is ignored.
//  Ack and timeout on the same edge: the ack wins, no retry, and Err is not set.
//  PC changes while Busy have no effect; the refill always uses addr_q.
//  A miss is not sampled again until IDLE.
//  CNT_STALL increments every cycle with state!=IDLE.
//  Both counters saturate at all-ones and do not wrap.
//  Data_MM holds its last value outside FILL.
// STRUCTURE
//  Shared package mips_mem_pkg:
//   - state encodings RF_IDLE/RF_REQ/RF_RETRY/RF_FILL/RF_COOL (3-bit)
//   - CNT_W default
//   - word-align mask
//  Sub-module sat_counter #(W): enable input, async active-low clear, saturating increment.
//  Instantiated twice (CNT_REFILL, CNT_STALL).
//  FSM, wait counter, addr_q/data_q registers stay in this module.
// TESTING
//  1 Reset: RESET=0 during REQ -> MM_Req=0, Access_MM=1, Busy=0 and all counters 0 without a clock edge.
//  2 Zero-wait: HitWrite=0 with PC=0x0040_0014; MM_Ack=1 and MM_RData=0xDEADBEEF on the first REQ cycle
//    -> MM_Addr=0x0040_0014; Access_MM=0 and Data_MM=0xDEADBEEF for one cycle; CNT_REFILL=1; CNT_STALL=3.
//  3 Wait states: ack after 5 REQ cycles -> FILL on the 7th cycle after the miss; CNT_STALL=8.
//    PC toggled mid-REQ -> MM_Addr unchanged.
//  4 Timeout (TIMEOUT=16): no ack -> MM_Req low for 1 cycle after 16 REQ cycles, Err=1, MM_Addr kept.
//    Then ack -> normal FILL and Err stays 1.
//  5 Stale-HitWrite/stray ack: HitWrite held 0 through COOL -> no second request.
//    MM_Ack pulsed in IDLE -> no FILL.
//  6 Saturation: force CNT_STALL to 0xFFFFE, then run 3 stall cycles -> CNT_STALL=0xFFFFF.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings and constants for the instruction-side memory controllers.
package mips_mem_pkg;

   typedef enum logic [2:0] {
      RF_IDLE  = 3'd0,
      RF_REQ   = 3'd1,
      RF_RETRY = 3'd2,
      RF_FILL  = 3'd3,
      RF_COOL  = 3'd4
   } rf_state_t;

   localparam int          CNT_W_DEF       = 20;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/mm_refill_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Single-cycle increment when enabled, asynchronous active-low clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;
   logic         w_full;

   assign w_full = &r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_en && !w_full) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mm_refill_ctrl.sv
// Instruction-cache miss refill controller: fetches one word from main memory per miss.
// Moore outputs; a zero-wait ack puts the refill word on Data_MM two cycles after the miss.
module mm_refill_ctrl
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [31:0]      PC,
   input  logic             HitWrite,
   output logic             Access_MM,
   output logic [31:0]      Data_MM,
   output logic             MM_Req,
   output logic [31:0]      MM_Addr,
   input  logic             MM_Ack,
   input  logic [31:0]      MM_RData,
   output logic             Busy,
   output logic             Err,
   output logic [CNT_W-1:0] CNT_REFILL,
   output logic [CNT_W-1:0] CNT_STALL
);

   localparam int                WAIT_W    = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   rf_state_t         r_state;
   rf_state_t         w_state_nxt;
   logic [WAIT_W-1:0] r_wait;
   logic [31:0]       r_addr_q;
   logic [31:0]       r_data_q;
   logic              r_access_mm;
   logic              r_mm_req;
   logic              r_busy;
   logic              r_err;
   logic              w_miss;
   logic              w_ack;
   logic              w_timeout;
   logic              w_refill_en;
   logic              w_stall_en;

   assign w_miss      = (r_state == RF_IDLE) && !HitWrite;
   assign w_ack       = (r_state == RF_REQ) && MM_Ack;
   // An ack on the final wait cycle takes priority over the timeout.
   assign w_timeout   = (r_state == RF_REQ) && !MM_Ack && (r_wait == WAIT_LAST);
   assign w_refill_en = (r_state == RF_FILL);
   assign w_stall_en  = (r_state != RF_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RF_IDLE: begin
            if (w_miss) begin
               w_state_nxt = RF_REQ;
            end
         end
         RF_REQ: begin
            if (w_ack) begin
               w_state_nxt = RF_FILL;
            end else if (w_timeout) begin
               w_state_nxt = RF_RETRY;
            end
         end
         RF_RETRY: w_state_nxt = RF_REQ;
         RF_FILL:  w_state_nxt = RF_COOL;
         // COOL never samples HitWrite: the cache's registered hit flag is still stale here.
         RF_COOL:  w_state_nxt = RF_IDLE;
         default:  w_state_nxt = RF_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state     <= RF_IDLE;
         r_wait      <= '0;
         r_addr_q    <= '0;
         r_data_q    <= '0;
         r_access_mm <= 1'b1;
         r_mm_req    <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == RF_REQ) && (w_state_nxt == RF_REQ)) begin
            r_wait <= r_wait + WAIT_W'(1);
         end else begin
            r_wait <= '0;
         end
         if (w_miss) begin
            r_addr_q <= word_align(PC);
         end
         if (w_ack) begin
            r_data_q <= MM_RData;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
         // Outputs are decoded from the next state so they appear registered with it.
         r_access_mm <= (w_state_nxt != RF_FILL);
         r_mm_req    <= (w_state_nxt == RF_REQ);
         r_busy      <= (w_state_nxt != RF_IDLE);
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt_refill (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_en    (w_refill_en),
      .o_cnt   (CNT_REFILL)
   );

   sat_counter #(.W(CNT_W)) u_cnt_stall (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_en    (w_stall_en),
      .o_cnt   (CNT_STALL)
   );

   assign Access_MM = r_access_mm;
   assign Data_MM   = r_data_q;
   assign MM_Req    = r_mm_req;
   assign MM_Addr   = r_addr_q;
   assign Busy      = r_busy;
   assign Err       = r_err;

endmodule
